// File: rtl/uart_tx_3byte.sv
// Sends a latched 24-bit word as three back-to-back UART frames (MSB byte first, LSB-first bits); 8N1, or 8E1 with UART_TX_PARITY_EN.
// Latency: start bit on tx one clk after accept; transfer lasts 3*10 (3*11 with parity) bit cells.
// Backpressure: start is accepted only while busy=0; requests during a transfer are dropped.
module uart_tx_3byte #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int NBYTES       = 3;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [1:0]    byte_idx, idx_n;
    logic [23:0]   shreg;
    logic          done_r, done_n;
    logic          load;
    logic          cell_end;
    logic [7:0]    cur_byte;

    assign cell_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cur_byte = shreg[7:0];
        case (byte_idx)
            2'd0:    cur_byte = shreg[23:16];
            2'd1:    cur_byte = shreg[15:8];
            default: cur_byte = shreg[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            byte_idx <= idx_n;
            done_r   <= done_n;
            if (load) begin
                shreg <= data_in;
            end
        end
    end

    // Every state change reloads the baud counter so cells never drift.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        idx_n   = byte_idx;
        done_n  = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = START;
                    baud_n  = '0;
                    bit_n   = '0;
                    idx_n   = '0;
                    load    = 1'b1;
                end
            end
            START: begin
                if (cell_end) begin
                    state_n = DATA;
                    baud_n  = '0;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (cell_end) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cell_end) begin
                    state_n = STOP;
                    baud_n  = '0;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cell_end) begin
                    baud_n = '0;
                    if (byte_idx == 2'(NBYTES - 1)) begin
                        state_n = IDLE;
                        idx_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = START;
                        idx_n   = byte_idx + 1'b1;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
            end
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = cur_byte[bit_cnt];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = ^cur_byte;
`endif
            default: tx = 1'b1;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = done_r;

endmodule
